// File: rtl/rst_sequencer_if.sv
// Pin bundle between the board-level reset sources and the reset sequencer.
// The testbench or board top drives the master side; the sequencer takes the slave side.
interface rst_sequencer_if #(
    parameter int NCH = 3
);
    logic           key_n_i;
    logic           soft_rst_i;
    logic           pll_locked_i;
    logic [NCH-1:0] rst_o;
    logic           ready_o;
    logic [3:0]     cause_o;

    modport master (
        output key_n_i, soft_rst_i, pll_locked_i,
        input  rst_o, ready_o, cause_o
    );

    modport slave (
        input  key_n_i, soft_rst_i, pll_locked_i,
        output rst_o, ready_o, cause_o
    );
endinterface

// File: rtl/rst_sequencer.sv
// Multi-domain reset sequencer: merges power-on, push-button, software and PLL-lock
// reset sources into NCH staged active-high resets and records the last reset cause.
module rst_sequencer #(
    parameter int NCH         = 3,
    parameter int HOLD_CYCLES = 32,
    parameter int STAGE_GAP   = 16,
    parameter int DEBOUNCE    = 1024,
    parameter int CNT_W       = 16
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    rst_sequencer_if.slave bus
);

    typedef enum logic [1:0] {ASSERT, WAIT_LOCK, RELEASE, RUN} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [NCH-1:0]   ALL_ON    = {NCH{1'b1}};
    // Output pattern on the edge that enters RELEASE; all zeros when NCH is 1.
    localparam logic [NCH-1:0]   FIRST_REL = ALL_ON << 1;

    logic             key_meta, key_sync, key_db;
    logic             lock_meta, lock_s;
    logic [CNT_W-1:0] deb_cnt;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d, gap_q, gap_d;
    logic [NCH-1:0]   rst_q, rst_d;
    logic             ready_q, ready_d;
    logic [3:0]       cause_q, cause_d, causes;
    logic             lock_lost, src;

    // Synchronisers start at 0 so lock is treated as lost until the PLL proves otherwise.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values,
        // which is what makes the 2-FF chains actually two stages deep.
        if (wb_rst_i) begin
            key_meta  <= 1'b0;
            key_sync  <= 1'b0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            key_db    <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            key_meta  <= bus.key_n_i;
            key_sync  <= key_meta;
            lock_meta <= bus.pll_locked_i;
            lock_s    <= lock_meta;
            if (key_sync == key_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                key_db  <= key_sync;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        rst_d     = rst_q;
        cause_d   = cause_q;
        lock_lost = (state_q == RELEASE || state_q == RUN) && !lock_s;
        causes    = {lock_lost, bus.soft_rst_i, ~key_db, 1'b0};
        src       = |causes;

        if (src) begin
            state_d = ASSERT;
            hold_d  = '0;
            gap_d   = '0;
            rst_d   = ALL_ON;
            cause_d = (state_q == RELEASE || state_q == RUN) ? causes : (cause_q | causes);
        end else begin
            case (state_q)
                ASSERT: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (lock_s) begin
                            rst_d   = FIRST_REL;
                            state_d = (FIRST_REL == '0) ? RUN : RELEASE;
                        end else begin
                            state_d = WAIT_LOCK;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        gap_d   = '0;
                        rst_d   = FIRST_REL;
                        state_d = (FIRST_REL == '0) ? RUN : RELEASE;
                    end
                end
                RELEASE: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        rst_d = rst_q << 1;
                        if (rst_d == '0) state_d = RUN;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                RUN:     rst_d = '0;
                default: state_d = ASSERT;
            endcase
        end

        ready_d = (state_d == RUN);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ASSERT;
            hold_q  <= '0;
            gap_q   <= '0;
            rst_q   <= ALL_ON;
            ready_q <= 1'b0;
            cause_q <= 4'b0001;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign bus.rst_o   = rst_q;
    assign bus.ready_o = ready_q;
    assign bus.cause_o = cause_q;

endmodule
